// File: rtl/cpu_fetch_ctrl_if.sv
// rtl/cpu_fetch_ctrl_if.sv - instruction memory and execute-stage handshake bundle
interface cpu_fetch_ctrl_if;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ready;
   logic [7:0] mem_rdata;
   logic [7:0] instr_out;
   logic       instr_valid;
   logic       instr_ack;

   modport master (
      output mem_req, mem_addr, instr_out, instr_valid,
      input  mem_ready, mem_rdata, instr_ack
   );

   modport slave (
      input  mem_req, mem_addr, instr_out, instr_valid,
      output mem_ready, mem_rdata, instr_ack
   );
endinterface

// File: rtl/cpu_fetch_ctrl.sv
// rtl/cpu_fetch_ctrl.sv - fetch sequencer: reads instructions at pc_addr, resolves JMP/HLT, issues the rest
module cpu_fetch_ctrl #(
   parameter logic [7:0] HLT_CODE   = 8'hFF,
   parameter logic [3:0] JMP_NIBBLE = 4'hE,
   parameter int         WAIT_LIMIT = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic [7:0]              pc_addr,
   cpu_fetch_ctrl_if.master        bus,
   output logic                    increment,
   output logic                    jumper,
   output logic [7:0]              jumper_d,
   output logic                    halted,
   output logic                    fault
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      FETCH_OP = 3'd2,
      ISSUE    = 3'd3,
      HALT     = 3'd4,
      FAULT    = 3'd5
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

   state_t     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         ir_q       <= 8'h00;
         wait_cnt_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         IDLE: begin
            if (run) begin
               state_d    = FETCH;
               wait_cnt_d = 8'h00;
            end
         end
         FETCH: begin
            if (bus.mem_ready) begin
               ir_d       = bus.mem_rdata;
               wait_cnt_d = 8'h00;
               if (bus.mem_rdata == HLT_CODE)
                  state_d = HALT;
               else if (bus.mem_rdata[7:4] == JMP_NIBBLE)
                  state_d = FETCH_OP;
               else
                  state_d = ISSUE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = FAULT;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         FETCH_OP: begin
            // The operand byte is consumed directly as the jump target; ir keeps the opcode.
            if (bus.mem_ready) begin
               wait_cnt_d = 8'h00;
               state_d    = run ? FETCH : IDLE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d = FAULT;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ISSUE: begin
            if (bus.instr_ack) begin
               wait_cnt_d = 8'h00;
               state_d    = run ? FETCH : IDLE;
            end
         end
         HALT:    state_d = HALT;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   // Reset low masks every output in the same cycle, even mid-access.
   always_comb begin
      bus.mem_req     = 1'b0;
      bus.mem_addr    = 8'h00;
      bus.instr_out   = 8'h00;
      bus.instr_valid = 1'b0;
      increment       = 1'b0;
      jumper          = 1'b0;
      jumper_d        = 8'h00;
      halted          = 1'b0;
      fault           = 1'b0;
      if (reset) begin
         bus.instr_out = ir_q;
         case (state_q)
            FETCH: begin
               bus.mem_req  = 1'b1;
               bus.mem_addr = pc_addr;
               increment    = bus.mem_ready && (bus.mem_rdata != HLT_CODE);
            end
            FETCH_OP: begin
               bus.mem_req  = 1'b1;
               bus.mem_addr = pc_addr;
               jumper       = bus.mem_ready;
               jumper_d     = bus.mem_ready ? bus.mem_rdata : 8'h00;
            end
            ISSUE:   bus.instr_valid = 1'b1;
            HALT:    halted = 1'b1;
            FAULT:   fault = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// tb/tb_cpu_fetch_ctrl.sv - scoreboard bench for cpu_fetch_ctrl with PC and memory models
module tb_cpu_fetch_ctrl;

   localparam int EV_MEM   = 0;
   localparam int EV_ISSUE = 1;
   localparam int EV_JMP   = 2;
   localparam int EV_HALT  = 3;
   localparam int EV_FAULT = 4;

   localparam int W_MEMREQ  = 0;
   localparam int W_VALID   = 1;
   localparam int W_HALTED  = 2;
   localparam int W_FAULT   = 3;
   localparam int W_FETCHOP = 4;

   typedef struct {
      int         kind;
      logic [7:0] val;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic [7:0] pc_addr = 8'h00;
   logic [7:0] pc_next;
   logic       increment, jumper, halted, fault;
   logic [7:0] jumper_d;

   logic [7:0] mem [256];
   int         waits = 0;
   int         wcnt = 0;

   ev_t        sb_q[$];
   int         checks = 0;
   int         errors = 0;
   int         inc_cnt = 0;
   int         jmp_cnt = 0;

   cpu_fetch_ctrl_if bus();

   cpu_fetch_ctrl #(.WAIT_LIMIT(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .pc_addr   (pc_addr),
      .bus       (bus),
      .increment (increment),
      .jumper    (jumper),
      .jumper_d  (jumper_d),
      .halted    (halted),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_push(input int kind, input logic [7:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input int kind, input logic [7:0] val, input string name);
      ev_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got unexpected event value %0h, expected no event", name, val);
      end else begin
         e = sb_q.pop_front();
         if (e.kind != kind || e.val !== val) begin
            errors++;
            $display("FAIL %s: got kind %0d value %0h expected kind %0d value %0h",
                     name, kind, val, e.kind, e.val);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_sig(input int which, input int budget, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(posedge clk);
         #1;
         case (which)
            W_MEMREQ:  hit = bus.mem_req;
            W_VALID:   hit = bus.instr_valid;
            W_HALTED:  hit = halted;
            W_FAULT:   hit = fault;
            W_FETCHOP: hit = bus.mem_req && (pc_addr == 8'h01);
            default:   hit = 1'b0;
         endcase
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL %s: timeout after %0d cycles, expected event", name, budget);
      end
   endtask

   task automatic check_zero(input string name);
      chk(name, {2'b00, bus.mem_req, bus.mem_addr, bus.instr_valid, bus.instr_out,
                 increment, jumper, jumper_d, halted, fault}, 32'h0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      run = 1'b0;
      bus.instr_ack = 1'b0;
      @(negedge clk);
      #2;
      check_zero("reset_outputs");
      repeat (2) @(posedge clk);
      #1;
      inc_cnt = 0;
      jmp_cnt = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   // Memory with programmable wait states plus the program counter it steers.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.mem_req) begin
            if (wcnt >= waits) begin
               bus.mem_ready = 1'b1;
               wcnt = 0;
            end else begin
               bus.mem_ready = 1'b0;
               wcnt++;
            end
         end else begin
            bus.mem_ready = 1'b0;
            wcnt = 0;
         end
         bus.mem_rdata = mem[bus.mem_addr];
         #1;
         if (!reset)         pc_next = 8'h00;
         else if (jumper)    pc_next = jumper_d;
         else if (increment) pc_next = pc_addr + 8'h01;
         else                pc_next = pc_addr;
         @(posedge clk);
         pc_addr = pc_next;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT shows an observable event.
   initial begin
      int   cyc = 0;
      int   req_rise = 0;
      logic req_prev = 1'b0;
      logic halt_prev = 1'b0;
      logic fault_prev = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (bus.mem_req && !req_prev) req_rise = cyc;
         if (bus.mem_req && bus.mem_ready) sb_pop(EV_MEM, bus.mem_addr, "mem_addr");
         if (jumper) sb_pop(EV_JMP, jumper_d, "jump_target");
         if (bus.instr_valid && bus.instr_ack) sb_pop(EV_ISSUE, bus.instr_out, "instr_out");
         if (halted && !halt_prev) sb_pop(EV_HALT, pc_addr, "halt_pc");
         if (fault && !fault_prev) sb_pop(EV_FAULT, 8'(cyc - req_rise), "fault_delay");
         if (increment || jumper) chk("inc_jmp_exclusive", {31'h0, increment & jumper}, 32'h0);
         if (increment) inc_cnt++;
         if (jumper) jmp_cnt++;
         req_prev   = bus.mem_req;
         halt_prev  = halted;
         fault_prev = fault;
      end
   end

   initial begin
      // Straight-line fetch, a jump, then halt at the target.
      do_reset();
      mem[8'h00] = 8'h12;
      mem[8'h01] = 8'hE0;
      mem[8'h02] = 8'h40;
      mem[8'h40] = 8'hFF;
      waits = 0;
      sb_push(EV_MEM, 8'h00);
      sb_push(EV_ISSUE, 8'h12);
      sb_push(EV_MEM, 8'h01);
      sb_push(EV_MEM, 8'h02);
      sb_push(EV_JMP, 8'h40);
      sb_push(EV_MEM, 8'h40);
      sb_push(EV_HALT, 8'h40);
      reset = 1'b1;
      run = 1'b1;
      bus.instr_ack = 1'b1;
      wait_sig(W_HALTED, 60, "wait_halt_jmp");
      tick(5);
      chk("halt_pc_hold", pc_addr, 8'h40);
      chk("halt_no_req", bus.mem_req, 0);
      chk("halt_flag", halted, 1);
      chk("inc_pulses", inc_cnt, 2);
      chk("jmp_pulses", jmp_cnt, 1);
      chk("sb_empty_t1", sb_q.size(), 0);

      // Memory never answers: fault 16 cycles after the request rises.
      do_reset();
      mem[8'h00] = 8'h12;
      waits = 999;
      sb_push(EV_FAULT, 8'd16);
      reset = 1'b1;
      run = 1'b1;
      bus.instr_ack = 1'b1;
      wait_sig(W_FAULT, 40, "wait_fault");
      tick(3);
      chk("fault_no_req", bus.mem_req, 0);
      chk("fault_flag", fault, 1);
      chk("fault_not_halted", halted, 0);
      chk("sb_empty_t4a", sb_q.size(), 0);

      // Ready arrives on the last allowed cycle: no fault.
      do_reset();
      mem[8'h00] = 8'h12;
      mem[8'h01] = 8'hFF;
      waits = 15;
      sb_push(EV_MEM, 8'h00);
      sb_push(EV_ISSUE, 8'h12);
      sb_push(EV_MEM, 8'h01);
      sb_push(EV_HALT, 8'h01);
      reset = 1'b1;
      run = 1'b1;
      bus.instr_ack = 1'b1;
      wait_sig(W_HALTED, 80, "wait_halt_slow");
      tick(2);
      chk("no_fault_at_limit", fault, 0);
      chk("sb_empty_t4b", sb_q.size(), 0);

      // run dropped during a 3-wait fetch: finish, issue, then idle.
      do_reset();
      mem[8'h00] = 8'h33;
      mem[8'h01] = 8'h44;
      mem[8'h02] = 8'hFF;
      waits = 3;
      sb_push(EV_MEM, 8'h00);
      sb_push(EV_ISSUE, 8'h33);
      reset = 1'b1;
      run = 1'b1;
      wait_sig(W_MEMREQ, 10, "wait_req_t5");
      run = 1'b0;
      wait_sig(W_VALID, 20, "wait_valid_t5");
      tick(2);
      chk("valid_held", bus.instr_valid, 1);
      chk("instr_held", bus.instr_out, 8'h33);
      bus.instr_ack = 1'b1;
      tick(1);
      bus.instr_ack = 1'b0;
      tick(2);
      chk("idle_no_req", bus.mem_req, 0);
      chk("idle_no_valid", bus.instr_valid, 0);
      chk("pc_after_issue", pc_addr, 8'h01);
      chk("sb_empty_t5a", sb_q.size(), 0);
      sb_push(EV_MEM, 8'h01);
      sb_push(EV_ISSUE, 8'h44);
      sb_push(EV_MEM, 8'h02);
      sb_push(EV_HALT, 8'h02);
      run = 1'b1;
      bus.instr_ack = 1'b1;
      wait_sig(W_HALTED, 40, "wait_halt_resume");
      tick(1);
      chk("sb_empty_t5b", sb_q.size(), 0);

      // Reset in the middle of a waiting operand fetch.
      do_reset();
      mem[8'h00] = 8'hE5;
      mem[8'h01] = 8'h80;
      waits = 2;
      sb_push(EV_MEM, 8'h00);
      reset = 1'b1;
      run = 1'b1;
      bus.instr_ack = 1'b1;
      wait_sig(W_FETCHOP, 20, "wait_fetch_op");
      reset = 1'b0;
      @(negedge clk);
      #2;
      check_zero("reset_mid_fetch_op");
      tick(2);
      run = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #2;
         chk("idle_after_reset", bus.mem_req, 0);
      end
      tick(1);
      chk("no_jump_pulse", jmp_cnt, 0);
      chk("sb_empty_t6", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
